regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_scoreboard.sv | 42 ++++
 rtl/regfile_mp.sv | 94 +++++++++
 tb/tb_regfile_mp.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and index-width helper for the multi-port register file.
// Consumers derive AW from NREGS through aw_of so every index is exactly AW bits.
package regfile_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int NWR_DEF   = 2;

    // Smallest w with 2**w >= n; NREGS is a power of two, so this is exact.
    function automatic int aw_of(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by an issue, cleared by any write-back to that index.
// When both hit one index in a cycle the issue wins, because it is the newer producer.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = NWR_DEF,
    parameter int AW    = aw_of(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_rd,
    output logic [NREGS-1:0]  busy
);

    logic [NREGS-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < NWR; i++) begin
            if (wr_en[i]) begin
                busy_nxt[wr_rd[i*AW +: AW]] = 1'b0;
            end
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data onto the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int NWR   = NWR_DEF,
    localparam int AW   = aw_of(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_rd,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [AW-1:0]    wr_idx [NWR];
    logic [XLEN-1:0]  wr_val [NWR];

    for (genvar i = 0; i < NWR; i++) begin : g_wr
        assign wr_idx[i] = wr_rd[i*AW +: AW];
        assign wr_val[i] = wr_data[i*XLEN +: XLEN];
    end

    // Later loop iterations overwrite earlier ones, so the highest port wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && (wr_idx[i] != '0)) begin
                    regs[wr_idx[i]] <= wr_val[i];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .wr_en     (wr_en),
        .wr_rd     (wr_rd),
        .busy      (busy)
    );

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rv;
        logic            rb;

        assign ra = rd_addr[j*AW +: AW];

        always_comb begin
            rv = regs[ra];
            rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
            // A forwarded value is no longer pending unless re-issued this cycle.
            if (!rst) begin
                for (int i = 0; i < NWR; i++) begin
                    if (wr_en[i] && (wr_idx[i] == ra)) begin
                        rv = wr_val[i];
                        rb = iss_valid && (iss_rd == ra);
                    end
                end
            end
`endif
            if (ra == '0) begin
                rv = '0;
                rb = 1'b0;
            end
        end

        assign rd_data[j*XLEN +: XLEN] = rv;
        assign rd_busy[j]              = rb;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed register-file cases, then random traffic
// compared against an array-based reference of register contents and busy bits.
module tb_regfile_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                rst;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_rd;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;

    int n_checks = 0;
    int n_errors = 0;

    bit [XLEN-1:0] m_regs [NREGS];
    bit            m_busy [NREGS];
    bit            model_valid = 1'b0;

    logic [XLEN-1:0] exp_q [$];
    logic            exp_busy_q [$];

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_rd     (wr_rd),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy)
    );

    // Clock and reset-default block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic idle();
        wr_en     = '0;
        wr_rd     = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
    endtask

    task automatic set_wr(input int port, input logic [AW-1:0] idx, input logic [XLEN-1:0] val);
        wr_en[port]               = 1'b1;
        wr_rd[port*AW +: AW]      = idx;
        wr_data[port*XLEN +: XLEN] = val;
    endtask

    task automatic set_iss(input logic [AW-1:0] idx);
        iss_valid = 1'b1;
        iss_rd    = idx;
    endtask

    task automatic set_rd(input int port, input logic [AW-1:0] idx);
        rd_addr[port*AW +: AW] = idx;
    endtask

    // Reference read: stored value and busy bit; x0 is zero; optional same-cycle forwarding.
    task automatic model_read(input logic [AW-1:0] a, output logic [XLEN-1:0] d, output logic b);
        d = m_regs[a];
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (!rst) begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && wr_rd[i*AW +: AW] == a) begin
                    d = wr_data[i*XLEN +: XLEN];
                    b = iss_valid && (iss_rd == a);
                end
            end
        end
`endif
        if (a == 0) begin
            d = '0;
            b = 1'b0;
        end
    endtask

    // Reference edge update: reset wipes all; otherwise writes in port order, then issue.
    task automatic model_edge();
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
            model_valid = 1'b1;
        end else if (model_valid) begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i]) begin
                    m_regs[wr_rd[i*AW +: AW]] = wr_data[i*XLEN +: XLEN];
                    m_busy[wr_rd[i*AW +: AW]] = 1'b0;
                end
            end
            if (iss_valid) m_busy[iss_rd] = 1'b1;
            m_regs[0] = '0;
            m_busy[0] = 1'b0;
        end
    endtask

    // Scoreboard: queue the reference results per port, then pop and compare.
    task automatic check_reads();
        logic [XLEN-1:0] d;
        logic            b;
        for (int j = 0; j < NRD; j++) begin
            model_read(rd_addr[j*AW +: AW], d, b);
            exp_q.push_back(d);
            exp_busy_q.push_back(b);
        end
        for (int j = 0; j < NRD; j++) begin
            d = exp_q.pop_front();
            b = exp_busy_q.pop_front();
            check($sformatf("model_rd_data[%0d]", j), rd_data[j*XLEN +: XLEN], d);
            check($sformatf("model_rd_busy[%0d]", j), {63'b0, rd_busy[j]}, {63'b0, b});
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (model_valid) check_reads();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic expect_rd(input string tag, input int port, input logic [XLEN-1:0] d, input logic b);
        #1;
        check({tag, "_data"}, rd_data[port*XLEN +: XLEN], d);
        check({tag, "_busy"}, {63'b0, rd_busy[port]}, {63'b0, b});
    endtask

    initial begin
        rst     = 1'b1;
        rd_addr = '0;
        idle();
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state of every register on both ports
        for (int a = 0; a < NREGS; a += 2) begin
            set_rd(0, AW'(a));
            set_rd(1, AW'(a + 1));
            expect_rd("reset_p0", 0, '0, 1'b0);
            expect_rd("reset_p1", 1, '0, 1'b0);
            cycle();
        end

        // Write x5 on port 0, read it on port 1 the next cycle
        idle();
        set_wr(0, 5'd5, 64'hDEAD_BEEF);
        cycle();
        idle();
        set_rd(1, 5'd5);
        expect_rd("x5_readback", 1, 64'hDEAD_BEEF, 1'b0);
        cycle();

        // Two ports hit x7 in one cycle: port 1 wins
        set_wr(0, 5'd7, 64'd1);
        set_wr(1, 5'd7, 64'd2);
        cycle();
        idle();
        set_rd(0, 5'd7);
        expect_rd("x7_port_priority", 0, 64'd2, 1'b0);
        cycle();

        // x0 ignores writes and issues
        set_wr(0, 5'd0, 64'hFFFF);
        set_iss(5'd0);
        cycle();
        idle();
        set_rd(0, 5'd0);
        set_rd(1, 5'd0);
        expect_rd("x0_p0", 0, '0, 1'b0);
        expect_rd("x0_p1", 1, '0, 1'b0);
        cycle();

        // Issue x3, then write-back and re-issue x3 together: busy stays set
        set_iss(5'd3);
        cycle();
        idle();
        set_rd(0, 5'd3);
        expect_rd("x3_issued", 0, '0, 1'b1);
        set_wr(1, 5'd3, 64'd9);
        set_iss(5'd3);
        cycle();
        idle();
        expect_rd("x3_set_beats_clear", 0, 64'd9, 1'b1);
        cycle();

        // Same-cycle write and read of x4 (x4 pending from a prior issue)
        set_wr(0, 5'd4, 64'h11);
        set_iss(5'd4);
        cycle();
        idle();
        set_wr(0, 5'd4, 64'h55);
        set_rd(0, 5'd4);
`ifdef REGFILE_BYPASS_EN
        expect_rd("x4_bypass", 0, 64'h55, 1'b0);
`else
        expect_rd("x4_no_bypass", 0, 64'h11, 1'b1);
`endif
        cycle();
        idle();
        expect_rd("x4_after", 0, 64'h55, 1'b0);
        cycle();

        // Randomized traffic with index collisions and occasional reset
        for (int n = 0; n < 400; n++) begin
            idle();
            rst = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < NWR; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_wr(i, ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 31))
                                                           : AW'($urandom_range(0, 7)),
                           {$urandom, $urandom});
                end
            end
            if ($urandom_range(0, 2) != 0) set_iss(AW'($urandom_range(0, 7)));
            for (int j = 0; j < NRD; j++) begin
                if ($urandom_range(0, 2) == 0) set_rd(j, wr_rd[0 +: AW]);
                else                           set_rd(j, AW'($urandom_range(0, 7)));
            end
            cycle();
        end
        rst = 1'b0;

        // Load registers and busy bits, then reset alongside a write and an issue
        idle();
        set_wr(0, 5'd9, 64'hAA);
        set_wr(1, 5'd10, 64'hBB);
        set_iss(5'd12);
        cycle();
        idle();
        set_iss(5'd9);
        cycle();
        idle();
        set_rd(0, 5'd9);
        set_rd(1, 5'd12);
        expect_rd("preload_x9", 0, 64'hAA, 1'b1);
        expect_rd("preload_x12", 1, '0, 1'b1);
        rst = 1'b1;
        set_wr(0, 5'd11, 64'h77);
        set_iss(5'd13);
        cycle();
        rst = 1'b0;
        idle();
        for (int a = 0; a < NREGS; a += 2) begin
            set_rd(0, AW'(a));
            set_rd(1, AW'(a + 1));
            expect_rd("post_reset_p0", 0, '0, 1'b0);
            expect_rd("post_reset_p1", 1, '0, 1'b0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
